rv32i_lsu: RTL and testbench

Load/store unit for the RV32I core: the memory-access stage that consumes the `MEM_*` mask-select codes produced by the decode/execute stages. It accepts one load or store per transaction and drives a single-outstanding request/ack data-memory port with byte enables and lane-replicated write data. It returns sign- or zero-extended load data, or a fault, to writeback. The pipeline stalls on `req_ready` low.

---
 rtl/rv32i_lsu.sv | 259 +++++++++++++++++++++++++
 tb/tb_rv32i_lsu.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single-outstanding request/ack data port, byte-lane formatting, fault reporting.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses at accept time.
module rv32i_lsu #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_fault
);

  localparam logic [3:0] MEM_LB   = 4'd0;
  localparam logic [3:0] MEM_LH   = 4'd1;
  localparam logic [3:0] MEM_LW   = 4'd2;
  localparam logic [3:0] MEM_LB_U = 4'd3;
  localparam logic [3:0] MEM_LH_U = 4'd4;
  localparam logic [3:0] MEM_SB   = 4'd5;
  localparam logic [3:0] MEM_SH   = 4'd6;
  localparam logic [3:0] MEM_SW   = 4'd7;

  // Counter holds at most ACK_TIMEOUT-1; one extra bit lets the increment be compared without wrap.
  localparam int          CW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_VAL = (CW+1)'(ACK_TIMEOUT);
  localparam bit          TO_EN  = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [4:0]    rsp_rd_q, rsp_rd_d;
  logic          rsp_fault_q, rsp_fault_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc_s;
  logic          timeout_s;
  logic          fault_s;

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
    logic m;
    case (op)
      MEM_LH, MEM_LH_U, MEM_SH: m = off[0];
      MEM_LW, MEM_SW:           m = (off != 2'b00);
      default:                  m = 1'b0;
    endcase
    return m;
  endfunction
`endif

  // Halfword lanes follow addr[1] only, so an untrapped odd halfword lands on its containing lane.
  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] off);
    logic [3:0] be;
    case (op)
      MEM_SB:  be = 4'b0001 << off;
      MEM_SH:  be = 4'b0011 << {off[1], 1'b0};
      MEM_SW:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    case (op)
      MEM_SB:  d = {4{wdata[7:0]}};
      MEM_SH:  d = {2{wdata[15:0]}};
      MEM_SW:  d = wdata;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LB:   r = {{24{b[7]}}, b};
      MEM_LB_U: r = {24'h00_0000, b};
      MEM_LH:   r = {{16{h[15]}}, h};
      MEM_LH_U: r = {16'h0000, h};
      MEM_LW:   r = rdata;
      default:  r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation for the IDLE/REQ/DONE access FSM.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    rsp_rd_d    = 5'd0;
    rsp_fault_d = 1'b0;
    cnt_inc_s   = {1'b0, cnt_q} + (CW+1)'(1);
    timeout_s   = TO_EN && (cnt_inc_s == TO_VAL);
`ifdef LSU_MISALIGN_TRAP_EN
    fault_s     = (req_op > MEM_SW) || misaligned(req_op, req_addr[1:0]);
`else
    fault_s     = (req_op > MEM_SW);
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          off_d = req_addr[1:0];
          rd_d  = req_rd;
          if (fault_s) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rd_d    = req_rd;
          end else begin
            state_d     = REQ;
            cnt_d       = {CW{1'b0}};
            mem_req_d   = 1'b1;
            mem_we_d    = is_store(req_op);
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = store_be(req_op, req_addr[1:0]);
            mem_wdata_d = store_data(req_op, req_wdata);
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack in the timeout cycle completes normally.
        if (mem_ack || timeout_s) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_be_d    = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          if (mem_ack) begin
            rsp_rdata_d = load_data(op_q, off_q, mem_rdata);
          end else begin
            rsp_fault_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'h0000_0000;
        mem_be_d    = 4'b0000;
        mem_wdata_d = 32'h0000_0000;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and registered-output flops; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_rd_q    <= 5'd0;
      rsp_fault_q <= 1'b0;
      op_q        <= 4'd0;
      off_q       <= 2'd0;
      rd_q        <= 5'd0;
      cnt_q       <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_fault_q <= rsp_fault_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: transaction-level reference model, per-cycle compare,
// plus a second instance with ACK_TIMEOUT=4 for directed timeout checks.
module tb_rv32i_lsu;

  localparam int TO_MAIN  = 255;
  localparam int TO_SMALL = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] OP_LB = 4'd0, OP_LH = 4'd1, OP_LW = 4'd2, OP_LBU = 4'd3,
                         OP_LHU = 4'd4, OP_SB = 4'd5, OP_SH = 4'd6, OP_SW = 4'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  logic        t_req_valid, t_req_ready;
  logic [3:0]  t_req_op;
  logic [31:0] t_req_addr, t_req_wdata;
  logic [4:0]  t_req_rd;
  logic        t_mem_req, t_mem_we, t_mem_ack;
  logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;
  logic [3:0]  t_mem_be;
  logic        t_rsp_valid, t_rsp_fault;
  logic [31:0] t_rsp_rdata;
  logic [4:0]  t_rsp_rd;

  rv32i_lsu #(.ACK_TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_fault(rsp_fault)
  );

  rv32i_lsu #(.ACK_TIMEOUT(TO_SMALL)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_op(t_req_op), .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_rd(t_req_rd),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
    .mem_wdata(t_mem_wdata), .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_rd(t_rsp_rd), .rsp_fault(t_rsp_fault)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  logic        e_req_ready, e_mem_req, e_mem_we, e_rsp_valid, e_rsp_fault;
  logic [31:0] e_mem_addr, e_mem_wdata, e_rsp_rdata;
  logic [3:0]  e_mem_be;
  logic [4:0]  e_rsp_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access rules written directly from the ISA byte-lane semantics.
  function automatic logic m_fault(input logic [3:0] op, input logic [31:0] a);
    logic half, word;
    half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word = (op == OP_LW) || (op == OP_SW);
    return (op > OP_SW) || (TRAP && ((half && a[0]) || (word && (a[1:0] != 2'b00))));
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    case (op)
      OP_SB:   return 4'(32'd1 << int'(a[1:0]));
      OP_SH:   return 4'(32'd3 << (2 * int'(a[1])));
      OP_SW:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
    case (op)
      OP_SB:   return 32'(w[7:0]) * 32'h0101_0101;
      OP_SH:   return 32'(w[15:0]) * 32'h0001_0001;
      OP_SW:   return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    case (op)
      OP_LB, OP_LBU: begin
        v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
        if (op == OP_LB && v >= 32'd128) v = v - 32'd256;
      end
      OP_LH, OP_LHU: begin
        v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
        if (op == OP_LH && v >= 32'h8000) v = v - 32'h1_0000;
      end
      OP_LW:   v = rd;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic set_idle_exp();
    e_req_ready = 1'b1; e_mem_req = 1'b0; e_mem_we = 1'b0; e_mem_addr = 32'h0;
    e_mem_be = 4'h0; e_mem_wdata = 32'h0; e_rsp_valid = 1'b0; e_rsp_rdata = 32'h0;
    e_rsp_rd = 5'd0; e_rsp_fault = 1'b0;
  endtask

  task automatic set_mem_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    set_idle_exp();
    e_req_ready = 1'b0; e_mem_req = 1'b1;
    e_mem_we    = (op >= OP_SB) && (op <= OP_SW);
    e_mem_addr  = a & 32'hFFFF_FFFC;
    e_mem_be    = m_be(op, a);
    e_mem_wdata = m_wdata(op, w);
  endtask

  task automatic set_rsp_exp(input logic [31:0] d, input logic [4:0] rd, input logic f);
    set_idle_exp();
    e_req_ready = 1'b0; e_rsp_valid = 1'b1; e_rsp_rdata = d; e_rsp_rd = rd; e_rsp_fault = f;
  endtask

  // Per-cycle comparison of the main instance against the model expectations.
  always begin
    @(posedge clk); #2;
    if (cmp_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_req_ready));
      chk("mem_req",   32'(mem_req),   32'(e_mem_req));
      if (e_mem_req) begin
        chk("mem_we",   32'(mem_we), 32'(e_mem_we));
        chk("mem_addr", mem_addr,    e_mem_addr);
        chk("mem_be",   32'(mem_be), 32'(e_mem_be));
        if (e_mem_we) chk("mem_wdata", mem_wdata, e_mem_wdata);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("rsp_rdata", rsp_rdata,      e_rsp_rdata);
      chk("rsp_rd",    32'(rsp_rd),    32'(e_rsp_rd));
      chk("rsp_fault", 32'(rsp_fault), 32'(e_rsp_fault));
    end
  end

  task automatic drive_garbage();
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 4'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_rd    = 5'($urandom);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  task automatic idle_cycle();
    @(negedge clk); #1;
    drive_garbage();
    req_valid = 1'b0;
    set_idle_exp();
  endtask

  // ack_at: REQ cycle (1-based) carrying mem_ack; 0 means never acknowledge.
  task automatic txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                     input logic [4:0] rd, input int ack_at, input logic [31:0] rdata);
    logic f;
    f = m_fault(op, a);
    @(negedge clk); #1;
    drive_garbage();
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w; req_rd = rd;
    if (f) set_rsp_exp(32'h0, rd, 1'b1);
    else   set_mem_exp(op, a, w);
    if (!f) begin
      for (int i = 1; i <= TO_MAIN + 1; i++) begin
        @(negedge clk); #1;
        drive_garbage();
        mem_ack = (i == ack_at);
        if (i == ack_at) begin
          mem_rdata = rdata;
          set_rsp_exp(m_load(op, a, rdata), rd, 1'b0);
          break;
        end else if (i == TO_MAIN) begin
          set_rsp_exp(32'h0, rd, 1'b1);
          break;
        end
      end
    end
    @(negedge clk); #1;
    drive_garbage();
    set_idle_exp();
  endtask

  task automatic t_run(input string name, input logic [3:0] op, input int ack_at,
                       input int exp_req_cycles, input int exp_rsp_cycle, input logic exp_fault);
    int   req_cnt;
    int   rsp_at;
    logic fault_seen;
    req_cnt = 0; rsp_at = -1; fault_seen = 1'b0;
    @(negedge clk); #1;
    t_req_valid = 1'b1; t_req_op = op; t_req_addr = 32'h0000_5000;
    t_req_wdata = 32'h1234_5678; t_req_rd = 5'd9; t_mem_ack = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #2;
      if (t_mem_req) req_cnt++;
      if (t_rsp_valid && rsp_at < 0) begin
        rsp_at = i;
        fault_seen = t_rsp_fault;
      end
      @(negedge clk); #1;
      t_req_valid = 1'b0;
      t_mem_ack   = (i == ack_at);
    end
    t_mem_ack = 1'b0;
    chk({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_req_cycles));
    chk({name, "_rsp_cycle"},  32'(rsp_at),  32'(exp_rsp_cycle));
    chk({name, "_fault"},      32'(fault_seen), 32'(exp_fault));
    chk({name, "_ready"},      32'(t_req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 4'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    t_req_valid = 1'b0; t_req_op = 4'd0; t_req_addr = 32'h0; t_req_wdata = 32'h0;
    t_req_rd = 5'd0; t_mem_ack = 1'b0; t_mem_rdata = 32'hDEAD_BEEF;
    set_idle_exp();
    #1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_mem_addr",  mem_addr,  32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    #1 rst_n = 1'b1;

    // Pin the model itself with hand-computed values.
    chk("pin_sb_be",  32'(m_be(OP_SB, 32'h0000_1003)), 32'h8);
    chk("pin_sb_wd",  m_wdata(OP_SB, 32'h0000_00AB), 32'hABAB_ABAB);
    chk("pin_lb",     m_load(OP_LB,  32'h0000_2001, 32'h0000_8000), 32'hFFFF_FF80);
    chk("pin_lbu",    m_load(OP_LBU, 32'h0000_2001, 32'h0000_8000), 32'h0000_0080);
    chk("pin_lh",     m_load(OP_LH,  32'h0000_3002, 32'h8001_0000), 32'hFFFF_8001);
    chk("pin_lw_flt", 32'(m_fault(OP_LW, 32'h0000_4002)), 32'(TRAP));

    // Directed timeout behaviour on the ACK_TIMEOUT=4 instance.
    t_run("to_noack", OP_LW, 0, 4, 5, 1'b1);
    t_run("to_ackwin", OP_LW, 4, 4, 5, 1'b0);
    t_run("to_badop", 4'd9, 0, 0, 1, 1'b1);

    // Directed accesses from the plan, then main-instance timeout and its ack-wins boundary.
    txn(OP_SB,  32'h0000_1003, 32'h0000_00AB, 5'd3, 1, 32'h5555_AAAA);
    txn(OP_LB,  32'h0000_2001, 32'h0,         5'd4, 1, 32'h0000_8000);
    txn(OP_LBU, 32'h0000_2001, 32'h0,         5'd5, 1, 32'h0000_8000);
    txn(OP_LH,  32'h0000_3002, 32'h0,         5'd6, 6, 32'h8001_0000);
    txn(OP_LW,  32'h0000_4002, 32'h0,         5'd7, 2, 32'hCAFE_F00D);
    txn(4'd9,   32'h0000_4000, 32'h0,         5'd8, 1, 32'h0);
    idle_cycle();
    txn(OP_SW,  32'h0000_7000, 32'h1122_3344, 5'd10, 0, 32'h0);
    txn(OP_LW,  32'h0000_7004, 32'h0,         5'd11, TO_MAIN, 32'h0BAD_F00D);

    // Reset during REQ, then a stale ack after release.
    @(negedge clk); #1;
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_6000; req_rd = 5'd12; mem_ack = 1'b0;
    set_mem_exp(OP_LW, 32'h0000_6000, 32'h0);
    repeat (2) begin
      @(negedge clk); #1;
      req_valid = 1'b0; mem_ack = 1'b0;
    end
    #1 rst_n = 1'b0;
    set_idle_exp();
    #1;
    chk("rst_async_mem_req", 32'(mem_req),   32'd0);
    chk("rst_async_ready",   32'(req_ready), 32'd1);
    chk("rst_async_rsp",     32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    mem_ack = 1'b0;
    idle_cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      txn(op, $urandom, $urandom, 5'($urandom), $urandom_range(1, 6), $urandom);
      for (int g = 0; g < $urandom_range(0, 2); g++) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    @(posedge clk); #3;
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
